// File: rtl/loopback_router_nch.sv
// N-channel USB CDC loopback/router: per-channel FIFOs with LOOP, ROTATE and DISCARD routing.
// Optional per-channel TX byte counters are enabled by defining LOOPBACK_STATS_EN.
module loopback_router_nch #(
    parameter int CHANNELS   = 2,
    parameter int FIFO_DEPTH = 8,
    parameter int DATA_W     = 8,
    localparam int LVL_W     = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [1:0]                   mode_i,
    input  logic [DATA_W*CHANNELS-1:0]   rx_data_i,
    input  logic [CHANNELS-1:0]          rx_valid_i,
    output logic [CHANNELS-1:0]          rx_ready_o,
    output logic [DATA_W*CHANNELS-1:0]   tx_data_o,
    output logic [CHANNELS-1:0]          tx_valid_o,
    input  logic [CHANNELS-1:0]          tx_ready_i,
    output logic [1:0]                   mode_o,
    output logic [LVL_W*CHANNELS-1:0]    level_o,
    output logic [16*CHANNELS-1:0]       stats_o
);

    typedef enum logic [1:0] {
        MODE_LOOP    = 2'd0,
        MODE_ROTATE  = 2'd1,
        MODE_DISCARD = 2'd2,
        MODE_RSVD    = 2'd3
    } mode_e;

    localparam int               PTR_W    = $clog2(FIFO_DEPTH);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

    mode_e               mode_q;
    logic                rotate;
    logic                discard;
    logic                all_idle;
    logic [CHANNELS-1:0] full;
    logic [CHANNELS-1:0] not_empty;
    logic [CHANNELS-1:0] rx_hs;
    logic [CHANNELS-1:0] push;
    logic [CHANNELS-1:0] pop;

    assign rotate  = (mode_q == MODE_ROTATE);
    assign discard = (mode_q == MODE_DISCARD);
    assign rx_hs   = rx_valid_i & rx_ready_o;

    // A mode switch only happens when nothing is in flight, so no byte is ever re-routed mid-stream.
    assign all_idle = ~|not_empty & ~|rx_hs;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mode_q <= MODE_LOOP;
        end else if (all_idle) begin
            mode_q <= mode_e'(mode_i);
        end
    end

    assign mode_o = mode_q;

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        localparam int NXT = (k + 1) % CHANNELS;
        localparam int PRV = (k + CHANNELS - 1) % CHANNELS;

        logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
        logic [PTR_W-1:0]  wr_ptr_q;
        logic [PTR_W-1:0]  rd_ptr_q;
        logic [LVL_W-1:0]  level_q;
        logic [DATA_W-1:0] push_data;

        assign full[k]      = (level_q == FULL_LVL);
        assign not_empty[k] = (level_q != '0);

        // Source k feeds FIFO NXT when rotating; FIFO k is fed by source PRV.
        assign rx_ready_o[k] = discard | (rotate ? ~full[NXT] : ~full[k]);
        assign push[k]       = ~rst_i & ~discard & (rotate ? rx_hs[PRV] : rx_hs[k]);
        assign push_data     = rotate ? rx_data_i[DATA_W*PRV +: DATA_W]
                                      : rx_data_i[DATA_W*k +: DATA_W];
        assign pop[k]        = not_empty[k] & tx_ready_i[k];

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                level_q  <= '0;
            end else begin
                if (push[k]) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                if (pop[k])  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                if (push[k] && !pop[k]) begin
                    level_q <= level_q + LVL_W'(1);
                end else if (!push[k] && pop[k]) begin
                    level_q <= level_q - LVL_W'(1);
                end
            end
        end

        // NOTE: storage is not reset; pointers and level alone decide validity, keeping it RAM-inferable.
        always_ff @(posedge clk_i) begin
            if (push[k]) mem_q[wr_ptr_q] <= push_data;
        end

        assign tx_valid_o[k]                 = not_empty[k];
        assign tx_data_o[DATA_W*k +: DATA_W] = mem_q[rd_ptr_q];
        assign level_o[LVL_W*k +: LVL_W]     = level_q;

`ifdef LOOPBACK_STATS_EN
        logic [15:0] stat_q;

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                stat_q <= '0;
            end else if (pop[k] && stat_q != 16'hFFFF) begin
                stat_q <= stat_q + 16'd1;
            end
        end

        assign stats_o[16*k +: 16] = stat_q;
`else
        assign stats_o[16*k +: 16] = '0;
`endif
    end

endmodule

// File: tb/tb_loopback_router_nch.sv
// Self-checking bench for loopback_router_nch: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_loopback_router_nch;

    localparam int CHANNELS   = 2;
    localparam int FIFO_DEPTH = 8;
    localparam int DATA_W     = 8;
    localparam int LVL_W      = $clog2(FIFO_DEPTH + 1);

    logic                        clk = 1'b0;
    logic                        rst;
    logic [1:0]                  mode_i;
    logic [DATA_W*CHANNELS-1:0]  rx_data;
    logic [CHANNELS-1:0]         rx_valid;
    logic [CHANNELS-1:0]         rx_ready;
    logic [DATA_W*CHANNELS-1:0]  tx_data;
    logic [CHANNELS-1:0]         tx_valid;
    logic [CHANNELS-1:0]         tx_ready;
    logic [1:0]                  mode_o;
    logic [LVL_W*CHANNELS-1:0]   level;
    logic [16*CHANNELS-1:0]      stats;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    loopback_router_nch #(
        .CHANNELS  (CHANNELS),
        .FIFO_DEPTH(FIFO_DEPTH),
        .DATA_W    (DATA_W)
    ) u_dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .mode_i    (mode_i),
        .rx_data_i (rx_data),
        .rx_valid_i(rx_valid),
        .rx_ready_o(rx_ready),
        .tx_data_o (tx_data),
        .tx_valid_o(tx_valid),
        .tx_ready_i(tx_ready),
        .mode_o    (mode_o),
        .level_o   (level),
        .stats_o   (stats)
    );

    // Reference model: one queue per destination FIFO, the current mode, and pop counts.
    logic [DATA_W-1:0] q [CHANNELS][$];
    int                m_mode;
    int                m_stats [CHANNELS];

    function automatic int dst_of(int k);
        return (m_mode == 1) ? (k + 1) % CHANNELS : k;
    endfunction

    function automatic logic [CHANNELS-1:0] exp_ready();
        logic [CHANNELS-1:0] r;
        for (int k = 0; k < CHANNELS; k++)
            r[k] = (m_mode == 2) ? 1'b1 : (q[dst_of(k)].size() != FIFO_DEPTH);
        return r;
    endfunction

    function automatic logic [CHANNELS-1:0] exp_valid();
        logic [CHANNELS-1:0] r;
        for (int k = 0; k < CHANNELS; k++) r[k] = (q[k].size() != 0);
        return r;
    endfunction

    function automatic logic [LVL_W*CHANNELS-1:0] exp_level();
        logic [LVL_W*CHANNELS-1:0] r;
        for (int k = 0; k < CHANNELS; k++) r[LVL_W*k +: LVL_W] = LVL_W'(q[k].size());
        return r;
    endfunction

    function automatic logic [16*CHANNELS-1:0] exp_stats();
        logic [16*CHANNELS-1:0] r;
        r = '0;
`ifdef LOOPBACK_STATS_EN
        for (int k = 0; k < CHANNELS; k++) r[16*k +: 16] = 16'(m_stats[k]);
`endif
        return r;
    endfunction

    task automatic model_update();
        logic [CHANNELS-1:0] hs;
        bit empty_all;
        if (rst) begin
            for (int k = 0; k < CHANNELS; k++) begin
                q[k].delete();
                m_stats[k] = 0;
            end
            m_mode = 0;
            return;
        end
        hs        = rx_valid & exp_ready();
        empty_all = (exp_valid() == '0);
        for (int k = 0; k < CHANNELS; k++) begin
            if (q[k].size() != 0 && tx_ready[k]) begin
                void'(q[k].pop_front());
                if (m_stats[k] < 65535) m_stats[k]++;
            end
        end
        if (m_mode != 2)
            for (int k = 0; k < CHANNELS; k++)
                if (hs[k]) q[dst_of(k)].push_back(rx_data[DATA_W*k +: DATA_W]);
        if (empty_all && hs == '0) m_mode = int'(mode_i);
    endtask

    // Advance one clock; DUT outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic test_reset();
        rx_valid = '1;
        rx_data  = {8'h77, 8'h66};
        tick();
        vectors++;
        if (level !== '0 || tx_valid !== '0) begin
            miscompares++;
            $display("FAIL reset_state: level=%h tx_valid=%b expected level=0 tx_valid=0", level, tx_valid);
        end
        vectors++;
        if (mode_o !== 2'd0 || stats !== '0) begin
            miscompares++;
            $display("FAIL reset_mode_stats: mode=%0d stats=%h expected 0/0", mode_o, stats);
        end
        vectors++;
        if (rx_ready !== 2'b11) begin
            miscompares++;
            $display("FAIL reset_ready: rx_ready=%b expected 11", rx_ready);
        end
        rx_valid = '0;
        rst      = 1'b0;
        tick();
    endtask

    task automatic test_loop();
        logic [7:0] bytes [3];
        bytes    = '{8'h41, 8'h42, 8'h43};
        mode_i   = 2'd0;
        tx_ready = '1;
        for (int i = 0; i < 3; i++) begin
            rx_valid = 2'b01;
            rx_data  = {8'h00, bytes[i]};
            tick();
            vectors++;
            if (tx_valid !== 2'b01 || tx_data[7:0] !== bytes[i]) begin
                miscompares++;
                $display("FAIL loop_byte%0d: tx_valid=%b data=%h expected 01/%h", i, tx_valid, tx_data[7:0], bytes[i]);
            end
        end
        rx_valid = '0;
        tick();
        vectors++;
        if (tx_valid !== 2'b00 || level !== '0) begin
            miscompares++;
            $display("FAIL loop_drained: tx_valid=%b level=%h expected 00/0", tx_valid, level);
        end
        tx_ready = '0;
    endtask

    task automatic test_rotate();
        mode_i = 2'd1;
        tick();
        vectors++;
        if (mode_o !== 2'd1) begin
            miscompares++;
            $display("FAIL rotate_mode: mode=%0d expected 1", mode_o);
        end
        rx_valid = 2'b11;
        rx_data  = {8'h20, 8'h10};
        tick();
        rx_valid = '0;
        vectors++;
        if (tx_valid !== 2'b11 || tx_data[15:8] !== 8'h10 || tx_data[7:0] !== 8'h20) begin
            miscompares++;
            $display("FAIL rotate_data: tx_valid=%b data=%h expected 11/1020", tx_valid, tx_data);
        end
        tx_ready = '1;
        tick();
        tx_ready = '0;
        vectors++;
        if (tx_valid !== 2'b00) begin
            miscompares++;
            $display("FAIL rotate_drained: tx_valid=%b expected 00", tx_valid);
        end
    endtask

    task automatic test_full();
        logic [7:0] sent [$];
        logic [7:0] b;
        mode_i = 2'd0;
        tick();
        vectors++;
        if (mode_o !== 2'd0) begin
            miscompares++;
            $display("FAIL full_mode: mode=%0d expected 0", mode_o);
        end
        for (int i = 0; i < 9; i++) begin
            b        = 8'($urandom);
            rx_valid = 2'b01;
            rx_data  = {8'h00, b};
            vectors++;
            if (rx_ready[0] !== (i < 8)) begin
                miscompares++;
                $display("FAIL full_ready%0d: rx_ready0=%b expected %0d", i, rx_ready[0], i < 8);
            end
            if (i < 8) sent.push_back(b);
            tick();
        end
        rx_valid = '0;
        vectors++;
        if (level[LVL_W-1:0] !== LVL_W'(8) || rx_ready[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL full_level: level0=%0d rx_ready0=%b expected 8/0", level[LVL_W-1:0], rx_ready[0]);
        end
        tx_ready = 2'b01;
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (tx_valid[0] !== 1'b1 || tx_data[7:0] !== sent[i]) begin
                miscompares++;
                $display("FAIL full_drain%0d: valid=%b data=%h expected 1/%h", i, tx_valid[0], tx_data[7:0], sent[i]);
            end
            tick();
        end
        tx_ready = '0;
        vectors++;
        if (level !== '0) begin
            miscompares++;
            $display("FAIL full_empty: level=%h expected 0", level);
        end
    endtask

    task automatic test_simultaneous();
        logic [7:0] sent [$];
        logic [7:0] b;
        for (int i = 0; i < 4; i++) begin
            b = 8'($urandom); rx_valid = 2'b01; rx_data = {8'h00, b};
            sent.push_back(b);
            tick();
        end
        b = 8'($urandom); rx_data = {8'h00, b}; tx_ready = 2'b01;
        sent.push_back(b);
        void'(sent.pop_front());
        tick();
        vectors++;
        if (level[LVL_W-1:0] !== LVL_W'(4) || tx_data[7:0] !== sent[0]) begin
            miscompares++;
            $display("FAIL pushpop_l4: level0=%0d head=%h expected 4/%h", level[LVL_W-1:0], tx_data[7:0], sent[0]);
        end
        tx_ready = '0;
        for (int i = 0; i < 4; i++) begin
            b = 8'($urandom); rx_data = {8'h00, b};
            sent.push_back(b);
            tick();
        end
        b = 8'($urandom); rx_data = {8'h00, b}; tx_ready = 2'b01;
        vectors++;
        if (rx_ready[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL pushpop_full_ready: rx_ready0=%b expected 0", rx_ready[0]);
        end
        void'(sent.pop_front());
        tick();
        rx_valid = '0;
        vectors++;
        if (level[LVL_W-1:0] !== LVL_W'(7)) begin
            miscompares++;
            $display("FAIL pushpop_l8: level0=%0d expected 7", level[LVL_W-1:0]);
        end
        for (int i = 0; i < 7; i++) begin
            vectors++;
            if (tx_data[7:0] !== sent[i] || tx_valid[0] !== 1'b1) begin
                miscompares++;
                $display("FAIL pushpop_order%0d: data=%h expected %h", i, tx_data[7:0], sent[i]);
            end
            tick();
        end
        tx_ready = '0;
    endtask

    task automatic test_mode_change();
        for (int i = 0; i < 3; i++) begin
            rx_valid = 2'b01; rx_data = {8'h00, 8'(8'hA0 + i)};
            tick();
        end
        rx_valid = '0;
        mode_i   = 2'd2;
        tx_ready = 2'b01;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (mode_o !== 2'd0) begin
                miscompares++;
                $display("FAIL mode_pending%0d: mode=%0d expected 0", i, mode_o);
            end
        end
        tick();
        vectors++;
        if (mode_o !== 2'd2) begin
            miscompares++;
            $display("FAIL mode_applied: mode=%0d expected 2", mode_o);
        end
        tx_ready = '1;
        for (int i = 0; i < 5; i++) begin
            rx_valid = 2'b11;
            rx_data  = DATA_W*CHANNELS'($urandom);
            vectors++;
            if (rx_ready !== 2'b11) begin
                miscompares++;
                $display("FAIL discard_ready%0d: rx_ready=%b expected 11", i, rx_ready);
            end
            tick();
            vectors++;
            if (tx_valid !== 2'b00 || level !== '0) begin
                miscompares++;
                $display("FAIL discard_drop%0d: tx_valid=%b level=%h expected 00/0", i, tx_valid, level);
            end
        end
        rx_valid = '0;
        tx_ready = '0;
    endtask

    task automatic test_reset_mid();
        mode_i = 2'd0;
        tick();
        for (int i = 0; i < 5; i++) begin
            rx_valid = 2'b01; rx_data = {8'h00, 8'($urandom)};
            tick();
        end
        rx_valid = '0;
        mode_i   = 2'd1;
        tick();
        vectors++;
        if (level[LVL_W-1:0] !== LVL_W'(5) || mode_o !== 2'd0) begin
            miscompares++;
            $display("FAIL midreset_pre: level0=%0d mode=%0d expected 5/0", level[LVL_W-1:0], mode_o);
        end
        rst = 1'b1;
        tick();
        mode_i = 2'd0;
        rst    = 1'b0;
        vectors++;
        if (level !== '0 || tx_valid !== '0 || mode_o !== 2'd0) begin
            miscompares++;
            $display("FAIL midreset_post: level=%h tx_valid=%b mode=%0d expected 0/00/0", level, tx_valid, mode_o);
        end
        tick();
    endtask

    task automatic test_stats();
        logic [16*CHANNELS-1:0] want;
        for (int i = 0; i < 3; i++) begin
            rx_valid = 2'b10; rx_data = {8'(8'h50 + i), 8'h00};
            tick();
        end
        rx_valid = '0;
        tx_ready = 2'b10;
        repeat (4) tick();
        tx_ready = '0;
`ifdef LOOPBACK_STATS_EN
        want = {16'd3, 16'd0};
`else
        want = '0;
`endif
        vectors++;
        if (stats !== want) begin
            miscompares++;
            $display("FAIL stats_count: stats=%h expected %h", stats, want);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++;
        if (stats !== '0) begin
            miscompares++;
            $display("FAIL stats_reset: stats=%h expected 0", stats);
        end
    endtask

    task automatic test_random();
        logic [CHANNELS-1:0] want_v;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 31) == 0) mode_i = 2'($urandom);
            rst      = ($urandom_range(0, 249) == 0);
            rx_valid = CHANNELS'($urandom);
            tx_ready = CHANNELS'($urandom) & CHANNELS'($urandom | $urandom);
            rx_data  = DATA_W*CHANNELS'($urandom);
            vectors++;
            if (rx_ready !== exp_ready()) begin
                miscompares++;
                $display("FAIL rand_ready@%0d: rx_ready=%b expected %b", n, rx_ready, exp_ready());
            end
            tick();
            want_v = exp_valid();
            vectors++;
            if (tx_valid !== want_v || level !== exp_level() || mode_o !== 2'(m_mode)) begin
                miscompares++;
                $display("FAIL rand_state@%0d: valid=%b level=%h mode=%0d expected %b/%h/%0d",
                         n, tx_valid, level, mode_o, want_v, exp_level(), m_mode);
            end
            vectors++;
            if (stats !== exp_stats()) begin
                miscompares++;
                $display("FAIL rand_stats@%0d: stats=%h expected %h", n, stats, exp_stats());
            end
            for (int k = 0; k < CHANNELS; k++) begin
                if (want_v[k]) begin
                    vectors++;
                    if (tx_data[DATA_W*k +: DATA_W] !== q[k][0]) begin
                        miscompares++;
                        $display("FAIL rand_data@%0d ch%0d: data=%h expected %h",
                                 n, k, tx_data[DATA_W*k +: DATA_W], q[k][0]);
                    end
                end
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        mode_i   = 2'd0;
        rx_valid = '0;
        rx_data  = '0;
        tx_ready = '0;
        m_mode   = 0;
        foreach (m_stats[k]) m_stats[k] = 0;
        tick();
        test_reset();
        test_loop();
        test_rotate();
        test_full();
        test_simultaneous();
        test_mode_change();
        test_reset_mid();
        test_stats();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
